// File: rtl/contador_distancia_param.sv
// Echo-pulse distance counter: pulse width in clock ticks -> BCD distance in cm or inch.
// Optional rounding at end of pulse with CONTADOR_DISTANCIA_ARREDONDAMENTO_EN (default: truncate).
module contador_distancia_param #(
  parameter int DIGITS   = 3,
  parameter int TICKS_CM = 2941,
  parameter int TICKS_IN = 7470,
  parameter int TICK_W   = 13
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                pulso,
  input  logic                unidade,
  output logic [4*DIGITS-1:0] distancia,
  output logic                pronto,
  output logic                ocupado,
  output logic                estouro,
  output logic [2:0]          db_estado
);

  localparam int BCD_W = 4 * DIGITS;
  localparam logic [TICK_W-1:0] LIM_CM = TICK_W'(TICKS_CM - 1);
  localparam logic [TICK_W-1:0] LIM_IN = TICK_W'(TICKS_IN - 1);

  typedef enum logic [2:0] {
    st_inicial = 3'b000,
    st_espera  = 3'b001,
    st_conta   = 3'b010,
    st_final   = 3'b011
  } estado_t;

  estado_t            estado, estado_nx;
  logic               pulso_ant;
  logic               unidade_lat, unidade_nx;
  logic [TICK_W-1:0]  tick, tick_nx;
  logic [BCD_W-1:0]   bcd, bcd_nx;
  logic               ovf, ovf_nx;
  logic [BCD_W-1:0]   dist_nx;
  logic               estouro_nx;

  logic               subida;
  logic               primeiro;
  logic [TICK_W-1:0]  lim;
  logic [TICK_W-1:0]  t_base;
  logic [BCD_W-1:0]   b_base;
  logic               o_base;
  logic               wrap;
  logic               cheio;
  logic [TICK_W-1:0]  step_tick;
  logic [BCD_W-1:0]   step_bcd;
  logic               step_ovf;
  logic [BCD_W-1:0]   res_bcd;
  logic               res_ovf;

  function automatic logic [BCD_W-1:0] bcd_inc(input logic [BCD_W-1:0] v);
    logic [BCD_W-1:0] r;
    logic             carry;
    logic [3:0]       d;
    r     = v;
    carry = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      d = v[4*i +: 4];
      if (carry) begin
        if (d == 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = d + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

  function automatic logic bcd_max(input logic [BCD_W-1:0] v);
    logic r;
    r = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (v[4*i +: 4] != 4'd9) r = 1'b0;
    end
    return r;
  endfunction

  assign subida = pulso & ~pulso_ant;

  // The rising-edge cycle is the first counted tick, so a measurement starts
  // from zeroed counters and the live unit select instead of the latched state.
  assign primeiro  = (estado != st_conta);
  assign lim       = (primeiro ? unidade : unidade_lat) ? LIM_IN : LIM_CM;
  assign t_base    = primeiro ? '0 : tick;
  assign b_base    = primeiro ? '0 : bcd;
  assign o_base    = primeiro ? 1'b0 : ovf;
  assign wrap      = (t_base == lim);
  assign cheio     = bcd_max(b_base);
  assign step_tick = wrap ? '0 : t_base + TICK_W'(1);
  assign step_bcd  = (wrap && !cheio) ? bcd_inc(b_base) : b_base;
  assign step_ovf  = o_base | (wrap & cheio);

`ifdef CONTADOR_DISTANCIA_ARREDONDAMENTO_EN
  localparam logic [TICK_W-1:0] HALF_CM = TICK_W'(TICKS_CM / 2);
  localparam logic [TICK_W-1:0] HALF_IN = TICK_W'(TICKS_IN / 2);
  logic [TICK_W-1:0] meio;
  logic              arred;
  assign meio    = unidade_lat ? HALF_IN : HALF_CM;
  assign arred   = (tick >= meio);
  assign res_bcd = (arred && !bcd_max(bcd)) ? bcd_inc(bcd) : bcd;
  assign res_ovf = ovf | (arred & bcd_max(bcd));
`else
  assign res_bcd = bcd;
  assign res_ovf = ovf;
`endif

  always_comb begin
    estado_nx  = estado;
    unidade_nx = unidade_lat;
    tick_nx    = tick;
    bcd_nx     = bcd;
    ovf_nx     = ovf;
    dist_nx    = distancia;
    estouro_nx = estouro;
    case (estado)
      st_inicial: begin
        tick_nx   = '0;
        bcd_nx    = '0;
        ovf_nx    = 1'b0;
        estado_nx = st_espera;
      end
      st_espera: begin
        if (subida) begin
          estado_nx  = st_conta;
          unidade_nx = unidade;
          tick_nx    = step_tick;
          bcd_nx     = step_bcd;
          ovf_nx     = step_ovf;
        end
      end
      st_conta: begin
        if (pulso) begin
          tick_nx = step_tick;
          bcd_nx  = step_bcd;
          ovf_nx  = step_ovf;
        end else begin
          estado_nx  = st_final;
          dist_nx    = res_bcd;
          estouro_nx = res_ovf;
        end
      end
      st_final: begin
        estado_nx = st_espera;
      end
      default: begin
        estado_nx = st_inicial;
      end
    endcase
  end

  // pulso_ant resets high so a level present at reset release is never an edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado      <= st_inicial;
      pulso_ant   <= 1'b1;
      unidade_lat <= 1'b0;
      tick        <= '0;
      bcd         <= '0;
      ovf         <= 1'b0;
      distancia   <= '0;
      estouro     <= 1'b0;
    end else begin
      estado      <= estado_nx;
      pulso_ant   <= pulso;
      unidade_lat <= unidade_nx;
      tick        <= tick_nx;
      bcd         <= bcd_nx;
      ovf         <= ovf_nx;
      distancia   <= dist_nx;
      estouro     <= estouro_nx;
    end
  end

  assign pronto    = (estado == st_final);
  assign ocupado   = (estado == st_conta);
  assign db_estado = estado;

endmodule

// File: tb/tb_contador_distancia_param.sv
// Randomized + directed bench for contador_distancia_param against an arithmetic reference model.
module tb_contador_distancia_param;

  localparam int DIGITS   = 2;
  localparam int TICKS_CM = 4;
  localparam int TICKS_IN = 10;
  localparam int TICK_W   = 4;

  logic                clock = 1'b0;
  logic                reset;
  logic                pulso;
  logic                unidade;
  logic [4*DIGITS-1:0] distancia;
  logic                pronto;
  logic                ocupado;
  logic                estouro;
  logic [2:0]          db_estado;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  contador_distancia_param #(
    .DIGITS  (DIGITS),
    .TICKS_CM(TICKS_CM),
    .TICKS_IN(TICKS_IN),
    .TICK_W  (TICK_W)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .pulso    (pulso),
    .unidade  (unidade),
    .distancia(distancia),
    .pronto   (pronto),
    .ocupado  (ocupado),
    .estouro  (estouro),
    .db_estado(db_estado)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] esp);
    checks++;
    if (obs !== esp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, esp);
    end
  endtask

  task automatic ciclo();
    @(posedge clock);
    #1;
  endtask

  // Reference: distance = floor(width / ticks) (optionally rounded), saturating at all nines.
  function automatic void modelo(input int n, input logic uni,
                                 output logic [4*DIGITS-1:0] bcd, output logic ovf);
    int t;
    int u;
    int maxv;
    t    = uni ? TICKS_IN : TICKS_CM;
    u    = n / t;
    maxv = 1;
    for (int i = 0; i < DIGITS; i++) maxv = maxv * 10;
    maxv = maxv - 1;
`ifdef CONTADOR_DISTANCIA_ARREDONDAMENTO_EN
    if ((n % t) >= (t / 2)) u = u + 1;
`endif
    ovf = (u > maxv);
    if (ovf) u = maxv;
    bcd = '0;
    for (int i = 0; i < DIGITS; i++) begin
      bcd[4*i +: 4] = 4'(u % 10);
      u = u / 10;
    end
  endfunction

  task automatic medir(input string tag, input int n, input logic uni, input bit troca);
    logic [4*DIGITS-1:0] eb;
    logic                eo;
    int                  pr;
    int                  oc_bad;
    pr     = 0;
    oc_bad = 0;
    modelo(n, uni, eb, eo);
    pulso   = 1'b1;
    unidade = uni;
    for (int i = 0; i < n; i++) begin
      ciclo();
      if (pronto) pr++;
      if (!ocupado) oc_bad++;
      if (troca && i == n / 2) unidade = ~unidade;
    end
    pulso = 1'b0;
    ciclo();
    check_val({tag, "_pronto_durante"}, pr, 0);
    check_val({tag, "_ocupado_durante"}, oc_bad, 0);
    check_val({tag, "_pronto"}, pronto, 1);
    check_val({tag, "_distancia"}, distancia, eb);
    check_val({tag, "_estouro"}, estouro, eo);
    check_val({tag, "_estado_final"}, db_estado, 3'b011);
    ciclo();
    check_val({tag, "_pronto_pulso"}, pronto, 0);
    check_val({tag, "_estado_espera"}, db_estado, 3'b001);
    check_val({tag, "_distancia_mantida"}, distancia, eb);
  endtask

  task automatic ocioso(input int k);
    pulso = 1'b0;
    for (int i = 0; i < k; i++) ciclo();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "bench watchdog expired");
  end

  initial begin
    int pc;
    logic [4*DIGITS-1:0] cap;
    logic capo;

    reset   = 1'b1;
    pulso   = 1'b0;
    unidade = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check_val("rst_estado", db_estado, 3'b000);
    check_val("rst_distancia", distancia, 0);
    check_val("rst_pronto", pronto, 0);
    check_val("rst_ocupado", ocupado, 0);
    check_val("rst_estouro", estouro, 0);
    reset = 1'b0;
    ciclo();
    check_val("pos_rst_espera", db_estado, 3'b001);
    ciclo();

    medir("p20cm", 20, 1'b0, 1'b0);
    ocioso(1);
    medir("p22cm", 22, 1'b0, 1'b0);
    ocioso(2);
    medir("p500cm", 500, 1'b0, 1'b0);
    medir("p8cm", 8, 1'b0, 1'b0);
    ocioso(1);
    medir("curto", 3, 1'b0, 1'b0);
    medir("um", 1, 1'b1, 1'b0);
    medir("p30in", 30, 1'b1, 1'b1);

    // Reset in the middle of a measurement
    ocioso(2);
    pulso   = 1'b1;
    unidade = 1'b0;
    repeat (10) ciclo();
    reset = 1'b1;
    #1;
    check_val("abort_estado", db_estado, 3'b000);
    check_val("abort_distancia", distancia, 0);
    check_val("abort_ocupado", ocupado, 0);
    check_val("abort_pronto", pronto, 0);
    pulso = 1'b0;
    ciclo();
    ciclo();
    reset = 1'b0;
    #1;
    check_val("abort_inicial", db_estado, 3'b000);
    ciclo();
    check_val("abort_espera", db_estado, 3'b001);
    pc = 0;
    for (int i = 0; i < 15; i++) begin
      ciclo();
      if (pronto) pc++;
    end
    check_val("abort_sem_pronto", pc, 0);
    check_val("abort_dist_final", distancia, 0);

    for (int k = 0; k < 16; k++) begin
      int  n;
      logic uni;
      bit  tr;
      n   = $urandom_range(1, 130);
      uni = 1'($urandom_range(0, 1));
      tr  = 1'($urandom_range(0, 1));
      ocioso($urandom_range(0, 3));
      medir($sformatf("rnd%0d_n%0d_u%0d", k, n, uni), n, uni, tr);
    end

    // Pulse already high at reset release must not start a measurement
    reset = 1'b1;
    pulso = 1'b1;
    unidade = 1'b0;
    ciclo();
    reset = 1'b0;
    pc   = 0;
    cap  = '0;
    capo = 1'b0;
    for (int i = 0; i < 28; i++) begin
      if (i < 12)       pulso = 1'b1;
      else if (i < 14)  pulso = 1'b0;
      else if (i < 22)  pulso = 1'b1;
      else              pulso = 1'b0;
      ciclo();
      if (pronto) begin
        pc++;
        cap  = distancia;
        capo = estouro;
      end
    end
    modelo(8, 1'b0, cap, capo);
    check_val("alto_rst_pronto_qtd", pc, 1);
    check_val("alto_rst_distancia", distancia, cap);
    check_val("alto_rst_estouro", estouro, capo);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/contador_distancia_param.md
CONTADOR_DISTANCIA_PARAM -- requirements
Module: contador_distancia_param

Interface
REQ-001 SHALL provide parameter DIGITS, default 3: number of BCD digits in the result.
REQ-002 SHALL provide parameter TICKS_CM, default 2941: clock cycles per centimetre (50 MHz, 58.82 us/cm).
REQ-003 SHALL provide parameter TICKS_IN, default 7470: clock cycles per inch (50 MHz, 149.4 us/in).
REQ-004 SHALL provide parameter TICK_W, default 13: tick-counter width, wide enough to hold max(TICKS_CM, TICKS_IN)-1.
REQ-005 SHALL have clock  input  1  system clock, rising edge.
REQ-006 SHALL have reset  input  1  asynchronous, active-high.
REQ-007 SHALL have pulso  input  1  echo pulse, already synchronous to clock.
REQ-008 SHALL have unidade  input  1  unit select: 0 = cm, 1 = inch.
REQ-009 SHALL have distancia  output  4*DIGITS  registered BCD result, least-significant digit in bits [3:0].
REQ-010 SHALL have pronto  output  1  one-cycle pulse when distancia is updated.
REQ-011 SHALL have ocupado  output  1  high while in state conta.
REQ-012 SHALL have estouro  output  1  registered overflow flag, updated together with distancia.
REQ-013 SHALL have db_estado  output  3  current state code, for debug.

Function
REQ-014 SHALL implement a Moore FSM with these states and codes: inicial=000, espera=001, conta=010, final=011.
REQ-015 inicial SHALL clear the tick counter and the BCD counter, then go unconditionally to espera.
REQ-016 espera SHALL go to conta only on a rising edge of pulso (pulso=1 this cycle, 0 in the previous cycle); the tick counter, BCD counter and overflow are cleared on that transition.
REQ-017 unidade SHALL be latched on the espera->conta transition; changes to unidade during conta SHALL be ignored.
REQ-018 In conta, the tick counter SHALL increment each cycle pulso=1. On reaching TICKS-1 (per the latched unit) it SHALL wrap to 0 in the same cycle and the BCD counter SHALL increment by 1.
REQ-019 BCD increments SHALL carry decimally; each digit SHALL stay in 0-9.
REQ-020 When the BCD counter is all 9s, a further increment SHALL hold the value and set the internal overflow.
REQ-021 pulso=0 sampled in conta SHALL move the FSM to final; on that same edge distancia and estouro SHALL be loaded.
REQ-022 final SHALL assert pronto for exactly one cycle, then go to espera.
REQ-023 Latency: pronto and the new distancia SHALL be visible in the first cycle after pulso is sampled low.
REQ-024 distancia and estouro SHALL hold their value between measurements.
REQ-025 A pulse lasting fewer than TICKS cycles SHALL produce distancia=0, with pronto still pulsed.
REQ-026 pulso already high when espera is entered SHALL not start a measurement until it goes low and rises again.

Reset
REQ-027 reset SHALL force inicial, distancia=0, estouro=0, pronto=0, ocupado=0, and clear all counters, regardless of the current state.
REQ-028 Asserting reset during conta SHALL abort the measurement with no pronto pulse.

Configuration
REQ-029 Macro CONTADOR_DISTANCIA_ARREDONDAMENTO_EN, when defined, SHALL round at the conta->final transition: if tick counter >= TICKS/2 (integer division), the loaded result is BCD+1, saturating at all 9s and setting estouro.
REQ-030 When CONTADOR_DISTANCIA_ARREDONDAMENTO_EN is undefined, the result SHALL be truncated (the BCD counter is loaded as-is).

Verification (DIGITS=2, TICKS_CM=4, TICKS_IN=10, TICK_W=4)
REQ-031 unidade=0, pulso high 20 cycles -> distancia=8'h05, estouro=0, pronto high for 1 cycle.
REQ-032 unidade=0, pulso high 22 cycles -> distancia=8'h05 without the macro; 8'h06 with the macro.
REQ-033 unidade=0, pulso high 500 cycles -> distancia=8'h99, estouro=1; a following 8-cycle pulse -> 8'h02, estouro=0.
REQ-034 unidade=1, pulso high 30 cycles, unidade toggled mid-pulse -> distancia=8'h03.
REQ-035 reset asserted 10 cycles into a pulse -> db_estado=000 then 001, distancia=8'h00, no pronto.
REQ-036 pulso high at reset release, held 12 cycles, then low 2 cycles, then high 8 cycles -> exactly one pronto, distancia=8'h02.
